// File: rtl/btb_nway.sv
// btb_nway: N-way set-associative branch target buffer with true-LRU.
// Ports: clk/rst, lookup (lk_*), update/invalidate (upd_*), ex_flush.
module btb_nway #(
  parameter int NUM_WAYS     = 4,
  parameter int NUM_SETS     = 16,
  parameter int TAG_WIDTH    = 20,
  parameter int TARGET_WIDTH = 32,
  localparam int IDX_W = $clog2(NUM_SETS),
  localparam int WAY_W = $clog2(NUM_WAYS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    lk_req,
  input  logic [IDX_W-1:0]        lk_index,
  input  logic [TAG_WIDTH-1:0]    lk_tag,
  output logic                    lk_rsp_valid,
  output logic                    lk_hit,
  output logic [TARGET_WIDTH-1:0] lk_target,
  output logic [WAY_W-1:0]        lk_way,
  input  logic                    upd_req,
  input  logic                    upd_inval,
  input  logic [IDX_W-1:0]        upd_index,
  input  logic [TAG_WIDTH-1:0]    upd_tag,
  input  logic [TARGET_WIDTH-1:0] upd_target,
  output logic                    upd_evict,
  input  logic                    ex_flush
);

  logic [NUM_WAYS-1:0]     valid_q [NUM_SETS];
  logic [WAY_W-1:0]        age_q   [NUM_SETS][NUM_WAYS];
  logic [TAG_WIDTH-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
  logic [TARGET_WIDTH-1:0] tgt_q   [NUM_SETS][NUM_WAYS];

  logic                    rsp_valid_q;
  logic                    hit_q;
  logic [TARGET_WIDTH-1:0] target_q;
  logic [WAY_W-1:0]        way_q;
  logic                    evict_q;

  logic             lk_hit_c;
  logic [WAY_W-1:0] lk_way_c;
  logic             up_hit;
  logic [WAY_W-1:0] up_way;
  logic             free;
  logic [WAY_W-1:0] free_way;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] wr_way;
  logic             upd_wr;
  logic             upd_kill;
  logic             lk_touch;

  // New age of one way when way with old age 'at' is touched.
  function automatic logic [WAY_W-1:0] aged(
    input logic [WAY_W-1:0] a,
    input logic [WAY_W-1:0] at,
    input logic             sel
  );
    if (sel)
      return '0;
    return (a < at) ? a + WAY_W'(1) : a;
  endfunction

  // Descending scans so the lowest-numbered way wins.
  always_comb begin
    lk_hit_c = 1'b0;
    lk_way_c = '0;
    up_hit   = 1'b0;
    up_way   = '0;
    free     = 1'b0;
    free_way = '0;
    lru_way  = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[lk_index][w] && tag_q[lk_index][w] == lk_tag) begin
        lk_hit_c = 1'b1;
        lk_way_c = WAY_W'(w);
      end
      if (valid_q[upd_index][w] && tag_q[upd_index][w] == upd_tag) begin
        up_hit = 1'b1;
        up_way = WAY_W'(w);
      end
      if (!valid_q[upd_index][w]) begin
        free     = 1'b1;
        free_way = WAY_W'(w);
      end
      if (age_q[upd_index][w] == WAY_W'(NUM_WAYS - 1))
        lru_way = WAY_W'(w);
    end
    wr_way   = up_hit ? up_way : (free ? free_way : lru_way);
    upd_wr   = upd_req && !upd_inval && !ex_flush;
    upd_kill = upd_req && upd_inval && up_hit && !ex_flush;
    // A write to the same set owns that set's LRU this cycle.
    lk_touch = lk_req && lk_hit_c && !ex_flush
               && !(upd_wr && lk_index == upd_index);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++)
          age_q[s][w] <= WAY_W'(w);
      end
    end else if (ex_flush) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++)
          age_q[s][w] <= WAY_W'(w);
      end
    end else begin
      if (upd_wr) begin
        valid_q[upd_index][wr_way] <= 1'b1;
        for (int w = 0; w < NUM_WAYS; w++)
          age_q[upd_index][w] <= aged(age_q[upd_index][w],
            age_q[upd_index][wr_way], WAY_W'(w) == wr_way);
      end
      if (upd_kill)
        valid_q[upd_index][up_way] <= 1'b0;
      if (lk_touch)
        for (int w = 0; w < NUM_WAYS; w++)
          age_q[lk_index][w] <= aged(age_q[lk_index][w],
            age_q[lk_index][lk_way_c], WAY_W'(w) == lk_way_c);
    end
  end

  // Payload arrays carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (upd_wr) begin
      tag_q[upd_index][wr_way] <= upd_tag;
      tgt_q[upd_index][wr_way] <= upd_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      target_q    <= '0;
      way_q       <= '0;
      evict_q     <= 1'b0;
    end else begin
      rsp_valid_q <= lk_req;
      hit_q       <= lk_req && lk_hit_c;
      target_q    <= (lk_req && lk_hit_c) ? tgt_q[lk_index][lk_way_c] : '0;
      way_q       <= (lk_req && lk_hit_c) ? lk_way_c : '0;
      evict_q     <= upd_wr && !up_hit && !free;
    end
  end

  assign lk_rsp_valid = rsp_valid_q;
  assign lk_hit       = hit_q;
  assign lk_target    = target_q;
  assign lk_way       = way_q;
  assign upd_evict    = evict_q;

endmodule

// File: tb/tb_btb_nway.sv
// tb_btb_nway: drives a 4x16 and an 8x64 btb_nway with common stimulus
// and checks the selected one against a recency-list reference model.
module tb_btb_nway;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lk_req = 1'b0;
  logic [5:0]  lk_index = '0;
  logic [19:0] lk_tag = '0;
  logic        upd_req = 1'b0;
  logic        upd_inval = 1'b0;
  logic [5:0]  upd_index = '0;
  logic [19:0] upd_tag = '0;
  logic [31:0] upd_target = '0;
  logic        ex_flush = 1'b0;

  logic        a_v, a_hit, a_ev, b_v, b_hit, b_ev;
  logic [31:0] a_tgt, b_tgt;
  logic [1:0]  a_way;
  logic [2:0]  b_way;

  bit          sel = 1'b0;
  logic        o_v, o_hit, o_ev;
  logic [31:0] o_tgt;
  logic [2:0]  o_way;

  assign o_v   = sel ? b_v : a_v;
  assign o_hit = sel ? b_hit : a_hit;
  assign o_ev  = sel ? b_ev : a_ev;
  assign o_tgt = sel ? b_tgt : a_tgt;
  assign o_way = sel ? b_way : {1'b0, a_way};

  always #5 clk = ~clk;

  btb_nway #(.NUM_WAYS(4), .NUM_SETS(16)) dut_a (
    .clk(clk), .rst(rst),
    .lk_req(lk_req), .lk_index(lk_index[3:0]), .lk_tag(lk_tag),
    .lk_rsp_valid(a_v), .lk_hit(a_hit), .lk_target(a_tgt), .lk_way(a_way),
    .upd_req(upd_req), .upd_inval(upd_inval), .upd_index(upd_index[3:0]),
    .upd_tag(upd_tag), .upd_target(upd_target), .upd_evict(a_ev),
    .ex_flush(ex_flush)
  );

  btb_nway #(.NUM_WAYS(8), .NUM_SETS(64)) dut_b (
    .clk(clk), .rst(rst),
    .lk_req(lk_req), .lk_index(lk_index), .lk_tag(lk_tag),
    .lk_rsp_valid(b_v), .lk_hit(b_hit), .lk_target(b_tgt), .lk_way(b_way),
    .upd_req(upd_req), .upd_inval(upd_inval), .upd_index(upd_index),
    .upd_tag(upd_tag), .upd_target(upd_target), .upd_evict(b_ev),
    .ex_flush(ex_flush)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per-set recency list, MRU first, LRU last.
  int          nw = 4;
  int          ns = 16;
  bit          mval [64][8];
  logic [19:0] mtag [64][8];
  logic [31:0] mtgt [64][8];
  int          rec  [64][$];

  bit          exp_v, exp_hit, exp_ev;
  int          exp_way;
  logic [31:0] exp_tgt;

  task automatic mreset();
    for (int s = 0; s < 64; s++) begin
      rec[s].delete();
      for (int w = 0; w < nw; w++) begin
        rec[s].push_back(w);
        mval[s][w] = 1'b0;
      end
    end
  endtask

  task automatic touch(input int s, input int t);
    for (int i = 0; i < rec[s].size(); i++)
      if (rec[s][i] == t) begin
        rec[s].delete(i);
        break;
      end
    rec[s].push_front(t);
  endtask

  task automatic find(input int s, input logic [19:0] tag,
                      output bit hit, output int way);
    hit = 1'b0;
    way = 0;
    for (int w = nw - 1; w >= 0; w--)
      if (mval[s][w] && mtag[s][w] == tag) begin
        hit = 1'b1;
        way = w;
      end
  endtask

  // Advance model by one cycle of the current inputs, then clock the DUTs.
  task automatic step();
    bit h, uh, wr;
    int w, uw, li, ui;
    li = int'(lk_index);
    ui = int'(upd_index);
    find(li, lk_tag, h, w);
    exp_v   = lk_req;
    exp_hit = lk_req && h;
    exp_way = exp_hit ? w : 0;
    exp_tgt = exp_hit ? mtgt[li][w] : 32'h0;
    exp_ev  = 1'b0;
    wr = upd_req && !upd_inval;
    if (ex_flush) begin
      mreset();
    end else begin
      if (upd_req) begin
        find(ui, upd_tag, uh, uw);
        if (upd_inval) begin
          if (uh) mval[ui][uw] = 1'b0;
        end else begin
          if (!uh) begin
            uw = -1;
            for (int k = 0; k < nw; k++)
              if (!mval[ui][k] && uw < 0) uw = k;
            if (uw < 0) begin
              uw = rec[ui][nw-1];
              exp_ev = 1'b1;
            end
          end
          mval[ui][uw] = 1'b1;
          mtag[ui][uw] = upd_tag;
          mtgt[ui][uw] = upd_target;
          touch(ui, uw);
        end
      end
      if (exp_hit && !(wr && ui == li)) touch(li, w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lk_req = 0; upd_req = 0; upd_inval = 0; ex_flush = 0;
  endtask

  task automatic do_lk(input int idx, input logic [19:0] tag);
    lk_req = 1; lk_index = 6'(idx); lk_tag = tag;
    step();
    lk_req = 0;
  endtask

  task automatic do_upd(input int idx, input logic [19:0] tag,
                        input logic [31:0] tgt);
    upd_req = 1; upd_inval = 0; upd_index = 6'(idx);
    upd_tag = tag; upd_target = tgt;
    step();
    upd_req = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_v, o_hit, o_ev, o_way, o_tgt} !== '0) begin
      errors++;
      $display("FAIL reset_outs got v%0b h%0b e%0b w%0d t%0h exp all 0",
               o_v, o_hit, o_ev, o_way, o_tgt);
    end
    rst = 0;
    mreset();
  endtask

  task automatic test_lookup_miss();
    do_lk(3, 20'h12345);
    checks++;
    if ({o_v, o_hit} !== 2'b10) begin
      errors++;
      $display("FAIL miss_vh got %0b%0b exp 10", o_v, o_hit);
    end
    checks++;
    if (o_tgt !== 32'h0 || o_way !== 3'd0) begin
      errors++;
      $display("FAIL miss_zero got t%0h w%0d exp 0 0", o_tgt, o_way);
    end
  endtask

  task automatic test_update_hit();
    do_upd(3, 20'h12345, 32'h8000_0040);
    checks++;
    if (o_ev !== 1'b0) begin
      errors++;
      $display("FAIL upd_evict got %0b exp 0", o_ev);
    end
    do_lk(3, 20'h12345);
    checks++;
    if (o_hit !== 1'b1 || o_tgt !== 32'h8000_0040 || o_way !== 3'd0) begin
      errors++;
      $display("FAIL upd_hit got h%0b t%0h w%0d exp 1 80000040 0",
               o_hit, o_tgt, o_way);
    end
  endtask

  task automatic test_lru();
    for (int w = 0; w < nw; w++)
      do_upd(5, 20'hA00 + 20'(w), 32'h1000 + 32'(w * 4));
    do_lk(5, 20'hA00);
    do_upd(5, 20'hE00, 32'h2000);
    checks++;
    if (o_ev !== 1'b1) begin
      errors++;
      $display("FAIL lru_evict got %0b exp 1", o_ev);
    end
    do_lk(5, 20'hE00);
    checks++;
    if (o_hit !== 1'b1 || o_way !== 3'd1 || o_tgt !== 32'h2000) begin
      errors++;
      $display("FAIL lru_way got h%0b w%0d t%0h exp 1 1 2000",
               o_hit, o_way, o_tgt);
    end
    do_lk(5, 20'hA01);
    checks++;
    if (o_hit !== 1'b0) begin
      errors++;
      $display("FAIL lru_victim got %0b exp 0", o_hit);
    end
    do_lk(5, 20'hA00);
    checks++;
    if (o_hit !== 1'b1 || o_way !== 3'd0) begin
      errors++;
      $display("FAIL lru_keep got h%0b w%0d exp 1 0", o_hit, o_way);
    end
  endtask

  task automatic test_target_update();
    do_upd(5, 20'hA02, 32'h3000);
    checks++;
    if (o_ev !== 1'b0) begin
      errors++;
      $display("FAIL tu_evict got %0b exp 0", o_ev);
    end
    do_lk(5, 20'hA02);
    checks++;
    if (o_hit !== 1'b1 || o_way !== 3'd2 || o_tgt !== 32'h3000) begin
      errors++;
      $display("FAIL tu_new got h%0b w%0d t%0h exp 1 2 3000",
               o_hit, o_way, o_tgt);
    end
    do_lk(5, 20'hA03);
    checks++;
    if (o_hit !== 1'b1 || o_way !== 3'd3 || o_tgt !== 32'h100C) begin
      errors++;
      $display("FAIL tu_other got h%0b w%0d t%0h exp 1 3 100c",
               o_hit, o_way, o_tgt);
    end
  endtask

  task automatic test_flush();
    logic [19:0] tg [4];
    int          ix [4];
    tg = '{20'hB00, 20'hB01, 20'hB02, 20'hA00};
    ix = '{7, 9, 7, 5};
    do_upd(7, 20'hB00, 32'h1);
    do_upd(9, 20'hB01, 32'h2);
    ex_flush = 1;
    do_upd(7, 20'hB02, 32'h3);
    ex_flush = 0;
    checks++;
    if (o_ev !== 1'b0) begin
      errors++;
      $display("FAIL flush_evict got %0b exp 0", o_ev);
    end
    for (int i = 0; i < 4; i++) begin
      do_lk(ix[i], tg[i]);
      checks++;
      if (o_v !== 1'b1 || o_hit !== 1'b0) begin
        errors++;
        $display("FAIL flush_miss%0d got v%0b h%0b exp 1 0", i, o_v, o_hit);
      end
    end
    do_upd(9, 20'hB03, 32'h4);
    do_lk(9, 20'hB03);
    checks++;
    if (o_hit !== 1'b1 || o_way !== 3'd0 || o_tgt !== 32'h4) begin
      errors++;
      $display("FAIL flush_alloc got h%0b w%0d t%0h exp 1 0 4",
               o_hit, o_way, o_tgt);
    end
  endtask

  task automatic test_same_cycle();
    do_upd(3, 20'h12345, 32'h8000_0040);
    lk_req = 1; lk_index = 6'd3; lk_tag = 20'h12345;
    do_upd(3, 20'h12345, 32'h8000_0080);
    lk_req = 0;
    checks++;
    if (o_hit !== 1'b1 || o_tgt !== 32'h8000_0040) begin
      errors++;
      $display("FAIL same_old got h%0b t%0h exp 1 80000040", o_hit, o_tgt);
    end
    do_lk(3, 20'h12345);
    checks++;
    if (o_hit !== 1'b1 || o_tgt !== 32'h8000_0080 || o_way !== 3'd0) begin
      errors++;
      $display("FAIL same_new got h%0b t%0h w%0d exp 1 80000080 0",
               o_hit, o_tgt, o_way);
    end
  endtask

  task automatic test_rst_mid();
    do_upd(2, 20'h777, 32'h77);
    lk_req = 1; lk_index = 6'd2; lk_tag = 20'h777;
    @(posedge clk);
    #1;
    rst = 1;
    #1;
    checks++;
    if (o_v !== 1'b0 || o_hit !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got v%0b h%0b exp 0 0", o_v, o_hit);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_v !== 1'b0) begin
      errors++;
      $display("FAIL rst_pending got %0b exp 0", o_v);
    end
    rst = 0;
    lk_req = 0;
    mreset();
    do_lk(2, 20'h777);
    checks++;
    if (o_v !== 1'b1 || o_hit !== 1'b0) begin
      errors++;
      $display("FAIL rst_resume got v%0b h%0b exp 1 0", o_v, o_hit);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      lk_req     = 1'($urandom_range(0, 1));
      lk_index   = 6'($urandom_range(0, 3));
      lk_tag     = 20'($urandom_range(0, nw + 2));
      upd_req    = ($urandom_range(0, 2) == 0);
      upd_inval  = ($urandom_range(0, 3) == 0);
      upd_index  = 6'($urandom_range(0, 3));
      upd_tag    = 20'($urandom_range(0, nw + 2));
      upd_target = 32'($urandom);
      ex_flush   = ($urandom_range(0, 59) == 0);
      step();
      checks++;
      if (o_v !== exp_v || o_hit !== exp_hit) begin
        errors++;
        $display("FAIL rnd_vh n%0d got %0b%0b exp %0b%0b",
                 n, o_v, o_hit, exp_v, exp_hit);
      end
      checks++;
      if (o_way !== 3'(exp_way) || o_tgt !== exp_tgt) begin
        errors++;
        $display("FAIL rnd_data n%0d got w%0d t%0h exp w%0d t%0h",
                 n, o_way, o_tgt, exp_way, exp_tgt);
      end
      checks++;
      if (o_ev !== exp_ev) begin
        errors++;
        $display("FAIL rnd_evict n%0d got %0b exp %0b", n, o_ev, exp_ev);
      end
    end
    idle();
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      sel = (c == 1);
      nw  = sel ? 8 : 4;
      ns  = sel ? 64 : 16;
      test_reset();
      test_lookup_miss();
      test_update_hit();
      test_lru();
      test_target_update();
      test_flush();
      test_same_cycle();
      test_rst_mid();
      test_random();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
